// File: rtl/fifo_rd_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_adapter
//
// Purpose:
//   Turns a fixed-latency synchronous FIFO read port into a valid/ready
//   stream. A pop issued at one edge returns its data on fifo_out, and that
//   data is captured into a 2-entry skid buffer at the next edge. Reads are
//   throttled so that buffered beats plus the one beat in flight never exceed
//   two. This gives one beat per cycle when the stream is never stalled, and
//   no beat is lost when the stream stalls.
//
// Handshake:
//   The downstream side is a valid/ready stream. A transfer (pop) happens on
//   a rising edge where m_valid=1 and m_ready=1. Once m_valid rises, it and
//   m_data hold steady until that transfer. m_valid never depends on m_ready.
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   en          in   1 = new FIFO reads may be issued
//   fifo_empty  in   upstream FIFO empty flag
//   fifo_out    in   upstream FIFO read data (valid one edge after the pop)
//   fifo_rd_en  out  pop request to the upstream FIFO (combinational)
//   m_data      out  stream data, head of the skid buffer
//   m_valid     out  stream data valid
//   m_ready     in   downstream ready
//   beat_count  out  completed stream transfers, wraps at 2^CNT_W
//   m_parity    out  XOR of m_data bits (only with FIFO_RD_ADAPTER_PARITY_EN)
//
// Build option:
//   `define FIFO_RD_ADAPTER_PARITY_EN to add the m_parity output.
// -----------------------------------------------------------------------------
module fifo_rd_adapter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_out,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] beat_count
`ifdef FIFO_RD_ADAPTER_PARITY_EN
    ,
    output logic             m_parity
`endif
);

    // Skid buffer storage and in-order pointers
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] beat_count_q, beat_count_d;

    logic             pop;
    logic [2:0]       occupancy;

    assign m_valid    = (count_q != 2'd0);
    assign m_data     = mem_q[rd_ptr_q];
    assign beat_count = beat_count_q;
    assign pop        = m_valid && m_ready;

    // Entries that will be held after this edge, before any new read is
    // counted. A pop requires count >= 1, so this never underflows. The
    // invariant count + inflight <= 2 keeps it within 0..2.
    assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    // reset_n is in the gate so that no pop request can leak out while
    // reset is held low. This matters when en=1 and the FIFO is not empty.
    assign fifo_rd_en = reset_n && en && !fifo_empty && (occupancy < 3'd2);

`ifdef FIFO_RD_ADAPTER_PARITY_EN
    assign m_parity = ^m_data;
`endif

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q ^ pop;
        wr_ptr_d     = wr_ptr_q ^ inflight_q;
        count_d      = occupancy[1:0];
        inflight_d   = fifo_rd_en;
        beat_count_d = beat_count_q;
        // The returning read lands at the tail in the same edge as a head
        // pop. With count==1 the two slots differ, so both can happen at once.
        if (inflight_q) begin
            mem_d[wr_ptr_q] = fifo_out;
        end
        if (pop) begin
            beat_count_d = beat_count_q + CNT_W'(1);
        end
    end

    // Clearing the storage as well as the pointers keeps m_data at zero
    // while reset is held low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            beat_count_q <= beat_count_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_adapter
//
// Purpose:
//   Self-checking bench for fifo_rd_adapter. The upstream synchronous FIFO is
//   a bench queue with one-cycle read latency. A queue-level model of the
//   adapter predicts m_valid, m_data, fifo_rd_en and beat_count every cycle.
//   A scoreboard checks that beats leave in the order they were written.
//   Directed scenarios add hand-computed literal expectations.
//
// Timing:
//   Inputs change at the falling edge. Outputs are sampled 3 time units
//   later. The upstream FIFO updates fifo_out 1 time unit after the rising
//   edge.
//
// beat_count is built 8 bits wide so that the wrap-around case stays short.
// -----------------------------------------------------------------------------
module tb_fifo_rd_adapter;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    // Clock/reset and DUT signals
    logic             clk;
    logic             reset_n;
    logic             en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_out;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CNT_W-1:0] beat_count;
`ifdef FIFO_RD_ADAPTER_PARITY_EN
    logic             m_parity;
`endif

    fifo_rd_adapter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_out   (fifo_out),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .beat_count (beat_count)
`ifdef FIFO_RD_ADAPTER_PARITY_EN
        ,
        .m_parity   (m_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Result counters
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO model and scoreboard
    logic [WIDTH-1:0] up_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             up_rd;

    initial begin
        up_rd = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            up_rd = fifo_rd_en;
            @(posedge clk);
            #1;
            if (up_rd && up_q.size() > 0) fifo_out = up_q.pop_front();
            fifo_empty = (up_q.size() == 0);
        end
    end

    // Behavioural model of the adapter, checked every cycle
    logic [WIDTH-1:0] mdl_buf[$];
    bit               mdl_fly;
    logic [WIDTH-1:0] mdl_fly_data;
    logic [CNT_W-1:0] mdl_beats;
    int               cyc = 0;
    int               rd_cnt = 0;
    int               pop_cyc[$];

    initial begin
        bit exp_valid;
        bit exp_pop;
        bit exp_rd;
        mdl_fly   = 1'b0;
        mdl_beats = '0;
        forever begin
            @(negedge clk);
            #3;
            cyc++;
            if (!reset_n) begin
                check("rst_m_valid", m_valid, 0);
                check("rst_m_data", m_data, 0);
                check("rst_fifo_rd_en", fifo_rd_en, 0);
                check("rst_beat_count", beat_count, 0);
`ifdef FIFO_RD_ADAPTER_PARITY_EN
                check("rst_m_parity", m_parity, 0);
`endif
                mdl_buf.delete();
                mdl_fly   = 1'b0;
                mdl_beats = '0;
            end else begin
                exp_valid = (mdl_buf.size() != 0);
                check("m_valid", m_valid, exp_valid);
                if (exp_valid) check("m_data", m_data, mdl_buf[0]);
`ifdef FIFO_RD_ADAPTER_PARITY_EN
                if (exp_valid) check("m_parity", m_parity, ^mdl_buf[0]);
`endif
                exp_pop = exp_valid && m_ready;
                exp_rd  = en && !fifo_empty &&
                          (mdl_buf.size() + int'(mdl_fly) - int'(exp_pop) < 2);
                check("fifo_rd_en", fifo_rd_en, exp_rd);
                check("beat_count", beat_count, mdl_beats);
                if (exp_pop) begin
                    if (exp_q.size() == 0) check("order_underrun", 1, 0);
                    else check("order", m_data, exp_q.pop_front());
                    void'(mdl_buf.pop_front());
                    mdl_beats = mdl_beats + 1'b1;
                    pop_cyc.push_back(cyc);
                end
                if (mdl_fly) mdl_buf.push_back(mdl_fly_data);
                mdl_fly = exp_rd;
                if (exp_rd) begin
                    mdl_fly_data = up_q[0];
                    rd_cnt++;
                end
            end
        end
    end

    // Driver tasks (all inputs change at the falling edge)
    task automatic push_bytes(input int n, input logic [WIDTH-1:0] first);
        for (int i = 0; i < n; i++) begin
            up_q.push_back(first + WIDTH'(i));
            exp_q.push_back(first + WIDTH'(i));
        end
        fifo_empty = (up_q.size() == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_now_m_valid", m_valid, 0);
        check("rst_now_fifo_rd_en", fifo_rd_en, 0);
        check("rst_now_beat_count", beat_count, 0);
        en      = 1'b0;
        m_ready = 1'b0;
        up_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_back_to_back(input string name, input int n);
        check({name, "_beats"}, pop_cyc.size(), n);
        for (int i = 1; i < pop_cyc.size(); i++) begin
            if (pop_cyc[i] != pop_cyc[i-1] + 1)
                check({name, "_gap"}, pop_cyc[i] - pop_cyc[i-1], 1);
        end
    endtask

    // Directed scenarios
    initial begin
        int t_start;
        int guard;
        reset_n    = 1'b0;
        en         = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_out   = '0;
        wait_cycles(3);
        reset_n = 1'b1;

        // Streaming 16 bytes: first beat two cycles after en, then gap-free
        do_reset();
        @(negedge clk);
        push_bytes(16, 8'h10);
        m_ready = 1'b1;
        en      = 1'b1;
        pop_cyc.delete();
        t_start = cyc + 1;
        wait_cycles(22);
        check("t1_first_beat_cycle", pop_cyc.size() > 0 ? pop_cyc[0] : -1, t_start + 2);
        check_back_to_back("t1", 16);
        check("t1_beat_count", beat_count, 16);
        check("t1_m_valid_idle", m_valid, 0);
        check("t1_sb_empty", exp_q.size(), 0);

        // m_ready toggling: 10 beats in order, head held while stalled
        do_reset();
        @(negedge clk);
        push_bytes(10, 8'h40);
        en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            m_ready = ~m_ready;
            @(negedge clk);
        end
        m_ready = 1'b1;
        wait_cycles(4);
        check("t2_beat_count", beat_count, 10);
        check("t2_sb_empty", exp_q.size(), 0);

        // Stalled stream with a full FIFO: exactly two reads, then no gap
        do_reset();
        @(negedge clk);
        push_bytes(16, 8'h80);
        en     = 1'b1;
        rd_cnt = 0;
        wait_cycles(20);
        #1;
        check("t3_reads_while_stalled", rd_cnt, 2);
        check("t3_rd_en_blocked", fifo_rd_en, 0);
        check("t3_m_valid_held", m_valid, 1);
        check("t3_head", m_data, 8'h80);
        pop_cyc.delete();
        m_ready = 1'b1;
        wait_cycles(22);
        check_back_to_back("t3", 16);
        check("t3_beat_count", beat_count, 16);

        // en dropped after 5 beats: buffered beats drain, then resume
        do_reset();
        @(negedge clk);
        push_bytes(8, 8'hA0);
        m_ready = 1'b1;
        en      = 1'b1;
        pop_cyc.delete();
        guard = 0;
        while (pop_cyc.size() < 5 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t4_reach_5_beats", guard < 50, 1);
        en = 1'b0;
        wait_cycles(10);
        check("t4_beats_after_drain", beat_count, 7);
        check("t4_m_valid_idle", m_valid, 0);
        check("t4_fifo_left", up_q.size(), 1);
        en = 1'b1;
        wait_cycles(6);
        check("t4_beat_count", beat_count, 8);
        check("t4_sb_empty", exp_q.size(), 0);

        // Reset pulsed mid-stream, then a fresh stream
        do_reset();
        @(negedge clk);
        push_bytes(12, 8'h20);
        m_ready = 1'b1;
        en      = 1'b1;
        wait_cycles(6);
        do_reset();
        @(negedge clk);
        push_bytes(6, 8'hC0);
        m_ready = 1'b1;
        en      = 1'b1;
        wait_cycles(12);
        check("t5_beat_count", beat_count, 6);
        check("t5_sb_empty", exp_q.size(), 0);

`ifdef FIFO_RD_ADAPTER_PARITY_EN
        // Parity of two known bytes
        do_reset();
        @(negedge clk);
        push_bytes(1, 8'hA5);
        push_bytes(1, 8'h07);
        en = 1'b1;
        wait_cycles(4);
        #1;
        check("t6_head_a5", m_data, 8'hA5);
        check("t6_parity_a5", m_parity, 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("t6_head_07", m_data, 8'h07);
        check("t6_parity_07", m_parity, 1);
        m_ready = 1'b1;
        wait_cycles(3);
`endif

        // beat_count wrap: 255 beats reach all-ones, one more wraps to 0
        do_reset();
        @(negedge clk);
        push_bytes(255, 8'h01);
        m_ready = 1'b1;
        en      = 1'b1;
        wait_cycles(265);
        check("t7_beat_count_max", beat_count, 8'hFF);
        push_bytes(1, 8'h55);
        wait_cycles(6);
        check("t7_beat_count_wrap", beat_count, 0);
        check("t7_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_adapter.md
FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 Parameter: WIDTH, default 8, data width; matches the upstream synchronous FIFO.
REQ-002 Parameter: CNT_W, default 16, beat counter width.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: en  input  1  1 = adapter may issue FIFO reads; 0 = no new reads issued.
REQ-006 Port: fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 Port: fifo_out  input  WIDTH  upstream FIFO read data.
REQ-008 Port: fifo_rd_en  output  1  pop request to upstream FIFO.
REQ-009 Port: m_data  output  WIDTH  stream data, head of skid buffer.
REQ-010 Port: m_valid  output  1  stream data valid.
REQ-011 Port: m_ready  input  1  downstream accepts when m_valid=1.
REQ-012 Port: beat_count  output  CNT_W  number of completed stream transfers.
REQ-013 Port: m_parity  output  1  even parity of m_data; present only with FIFO_RD_ADAPTER_PARITY_EN.

Function
REQ-014 Upstream read latency is fixed: data popped with fifo_rd_en=1 at edge N appears on fifo_out after edge N and is captured at edge N+1.
REQ-015 Block keeps a 2-entry in-order skid buffer (count 0..2) and an inflight bit (1 = a pop was issued at the previous edge).
REQ-016 pop = m_valid && m_ready; a pop removes the buffer head at the edge.
REQ-017 fifo_rd_en = en && !fifo_empty && (count + inflight - pop) < 2, combinational.
REQ-018 When inflight=1 at an edge, fifo_out is written to the buffer tail at that edge, in the same edge as any pop.
REQ-019 m_valid = (count != 0); m_data = buffer head; both depend only on registered state.
REQ-020 m_valid, once asserted, stays asserted with m_data stable until pop (AXI-stream rule).
REQ-021 Sustained throughput: with fifo non-empty, en=1 and m_ready=1 constantly, one beat per cycle after a 2-cycle startup.
REQ-022 Buffer never overflows: count + inflight never exceeds 2.
REQ-023 en deassertion stops new reads only; in-flight and buffered data still drain to the stream.
REQ-024 beat_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
REQ-025 Data order at m_data equals FIFO pop order; no beat is dropped or duplicated.

Reset
REQ-026 reset_n=0 asynchronously clears count, inflight, buffer pointers and beat_count; m_valid=0, m_data=0, fifo_rd_en=0, m_parity=0 while reset is low.
REQ-027 A pop in flight at reset assertion is discarded; the upstream FIFO shares reset_n, so no data is lost relative to it.
REQ-028 After reset_n rises, the first fifo_rd_en is issued no earlier than the first edge following release.

Configuration
REQ-029 Macro FIFO_RD_ADAPTER_PARITY_EN defined: m_parity port exists, m_parity = XOR of all m_data bits, combinational from the buffer head.
REQ-030 Macro FIFO_RD_ADAPTER_PARITY_EN undefined: m_parity port and its logic are absent; all other behaviour identical.

Verification
REQ-031 Reset then write 16 bytes to the FIFO, en=1, m_ready=1 -> 16 beats in write order on consecutive cycles after the startup, beat_count=16, m_valid=0 afterwards.
REQ-032 FIFO holding 10 bytes, m_ready toggled 1/0 each cycle -> all 10 beats delivered in order, m_data stable while m_valid=1 and m_ready=0, count never >2.
REQ-033 m_ready=0 for 20 cycles with a full FIFO -> exactly 2 pops issued, then fifo_rd_en=0; on m_ready=1, remaining 14 bytes follow the buffered 2 with no gap.
REQ-034 en dropped after 5 beats with 8 bytes queued -> buffered/in-flight beats still delivered, then m_valid=0, fifo_empty=0 held; en=1 resumes from byte 6 or later in order.
REQ-035 reset_n pulsed low mid-stream -> m_valid, fifo_rd_en, beat_count immediately 0; after release, new writes stream correctly.
REQ-036 With FIFO_RD_ADAPTER_PARITY_EN: m_data 8'hA5 -> m_parity 0; 8'h07 -> m_parity 1; preload beat_count 16'hFFFF via 65535 beats, one more beat -> 0.
